// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling with 3-sample majority vote,
// configurable data/parity/stop format and a valid/ready output handshake.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock_fpga,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // state     | meaning
  // IDLE      | line idle, watching for a low sample
  // START     | validating the start bit (false-start rejection)
  // DATA      | shifting in DATA_BITS data bits, LSB first
  // PARITY    | checking the parity bit
  // STOP      | voting the stop bit(s); final decision completes the frame
  // WAIT_HIGH | line stuck low after a bad stop bit, wait for idle
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  IDX_LO   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  IDX_MID  = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0]  IDX_DEC  = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0]  IDX_END  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic                 rxd_meta, rxd_sync;
  logic [SC_W-1:0]      sample_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 stop_cnt;
  logic                 samp_lo, samp_mid;
  logic                 vote;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_exp;
  logic                 perr_acc, ferr_acc;
  logic                 done;
  state_t               state, state_next;

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n)              div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // The third sample is taken live on the decision tick.
  assign vote    = (samp_lo & samp_mid) | (samp_lo & rxd_sync) | (samp_mid & rxd_sync);
  assign par_exp = (PARITY == 2) ? ~(^shift_reg) : ^shift_reg;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE:
          if (!rxd_sync) state_next = S_START;
        S_START:
          if (sample_cnt == IDX_DEC && vote) state_next = S_IDLE;
          else if (sample_cnt == IDX_END)    state_next = S_DATA;
        S_DATA:
          if (sample_cnt == IDX_END && bit_cnt == BC_LAST)
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY:
          if (sample_cnt == IDX_END) state_next = S_STOP;
        S_STOP:
          if (sample_cnt == IDX_DEC && stop_cnt == STOP_LAST) begin
            done       = 1'b1;
            state_next = vote ? S_IDLE : S_WAIT_HIGH;
          end
        S_WAIT_HIGH:
          if (rxd_sync) state_next = S_IDLE;
        default:
          state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      samp_lo    <= 1'b0;
      samp_mid   <= 1'b0;
      shift_reg  <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
    end else if (tick) begin
      if (state == S_IDLE || state == S_WAIT_HIGH ||
          state_next == S_IDLE || state_next == S_WAIT_HIGH)
        sample_cnt <= '0;
      else if (sample_cnt == IDX_END)
        sample_cnt <= '0;
      else
        sample_cnt <= sample_cnt + 1'b1;

      if (state == S_IDLE) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end

      if (sample_cnt == IDX_LO)  samp_lo  <= rxd_sync;
      if (sample_cnt == IDX_MID) samp_mid <= rxd_sync;

      if (sample_cnt == IDX_DEC) begin
        case (state)
          S_DATA:   shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
          S_PARITY: perr_acc  <= vote ^ par_exp;
          S_STOP:   if (!vote) ferr_acc <= 1'b1;
          default:  ;
        endcase
      end

      if (sample_cnt == IDX_END) begin
        case (state)
          S_DATA:  bit_cnt  <= bit_cnt + 1'b1;
          S_STOP:  stop_cnt <= stop_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A handshake in the same cycle as a completion frees the slot for the new word.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shift_reg;
        parity_err <= perr_acc;
        frame_err  <= ferr_acc | ~vote;
        rx_valid   <= 1'b1;
        if (rx_valid) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
